snn_image_loader: RTL



---
 rtl/snn_pkg.sv | 22 ++
 rtl/snn_byte_unpacker.sv | 33 +++
 rtl/snn_image_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN image loader.
package snn_pkg;

    localparam int         NUM_PIXELS_DEF = 784;
    localparam logic [7:0] ASCII_ZERO     = 8'h30;
    localparam logic [7:0] ASCII_QMARK    = 8'h3F;

    typedef enum logic [2:0] {
        WAIT_BYTE = 3'd0,
        UNPACK    = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        SEND      = 3'd4,
        WAIT_TX   = 3'd5
    } loader_state_t;

    // Digits 0..9 map to '0'..'9'; anything else is reported as '?'.
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
        return (d > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'h0, d});
    endfunction

endpackage

// File: rtl/snn_byte_unpacker.sv
// Holds one received byte and presents its bits LSB first, one per shift.
module snn_byte_unpacker
    import snn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    output logic       bit_out,
    output logic       last_bit
);

    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (load) begin
            shreg   <= din;
            bit_cnt <= 3'd0;
        end else if (shift) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign bit_out  = shreg[0];
    assign last_bit = (bit_cnt == 3'd7);

endmodule

// File: rtl/snn_image_loader.sv
// Loads a packed binary image from UART into the SNN input RAM, runs the core, returns the digit.
// Optional build macro SNN_LOADER_TIMEOUT_EN adds an inter-byte idle timeout that resyncs the frame.
//
// state     | meaning
// WAIT_BYTE | idle, waiting for uart_rx to hold a byte
// UNPACK    | writing the 8 bits of the held byte to RAM
// START     | pulsing snn_start, rewinding the pixel counter
// WAIT_DONE | core running, waiting for snn_done
// SEND      | waiting for the transmitter to be free
// WAIT_TX   | waiting for the transmitter to finish the byte
module snn_image_loader
    import snn_pkg::*;
#(
    parameter int NUM_PIXELS  = NUM_PIXELS_DEF,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       rx_rdy_clr,
    output logic       ram_we,
    output logic [9:0] ram_addr,
    output logic       ram_d,
    output logic       snn_start,
    input  logic       snn_done,
    input  logic [3:0] snn_digit,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [3:0] digit
);

    if ((NUM_PIXELS % 8) != 0 || NUM_PIXELS < 8 || NUM_PIXELS > 1024) begin : g_bad_num_pixels
        $error("NUM_PIXELS must be a multiple of 8 in 8..1024");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 8_388_607) begin : g_bad_timeout
        $error("TIMEOUT_CYC must fit a 23-bit counter");
    end

    localparam logic [9:0] PIX_LAST = 10'(NUM_PIXELS - 1);

    loader_state_t state, next_state;
    logic [9:0]    pix_cnt;
    logic          seen_busy;
    logic          byte_load, bit_shift, send_fire, done_take;
    logic          last_bit, idle_expired;

    snn_byte_unpacker u_unpacker (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (byte_load),
        .shift    (bit_shift),
        .din      (rx_data),
        .bit_out  (ram_d),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_BYTE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_BYTE: if (rx_rdy)    next_state = UNPACK;
            UNPACK:    if (last_bit)  next_state = (pix_cnt == PIX_LAST) ? START : WAIT_BYTE;
            START:                    next_state = WAIT_DONE;
            WAIT_DONE: if (snn_done)  next_state = SEND;
            SEND:      if (!tx_busy)  next_state = WAIT_TX;
            WAIT_TX:   if (seen_busy && !tx_busy) next_state = WAIT_BYTE;
            default:                  next_state = WAIT_BYTE;
        endcase
    end

    always_comb begin
        byte_load = (state == WAIT_BYTE) && rx_rdy;
        bit_shift = (state == UNPACK);
        send_fire = (state == SEND) && !tx_busy;
        done_take = (state == WAIT_DONE) && snn_done;
    end

    // Strobes are flopped from the decoded next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy_clr <= 1'b0;
            ram_we     <= 1'b0;
            snn_start  <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            digit      <= 4'h0;
            seen_busy  <= 1'b0;
        end else begin
            rx_rdy_clr <= byte_load;
            ram_we     <= (next_state == UNPACK);
            snn_start  <= (next_state == START);
            tx_start   <= send_fire;
            if (send_fire) tx_data <= digit_to_ascii(digit);
            if (done_take) digit   <= snn_digit;
            if (state != WAIT_TX) seen_busy <= 1'b0;
            else if (tx_busy)     seen_busy <= 1'b1;
        end
    end

    // pix_cnt is the address of the bit being written; it saturates on the final pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  pix_cnt <= 10'd0;
        else if (state == START || idle_expired)     pix_cnt <= 10'd0;
        else if (bit_shift && pix_cnt != PIX_LAST)   pix_cnt <= pix_cnt + 10'd1;
    end

    assign ram_addr = pix_cnt;

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam logic [22:0] IDLE_LOAD = 23'(TIMEOUT_CYC - 1);

    logic [22:0] idle_cnt;
    logic        idle_run;

    assign idle_run = (state == WAIT_BYTE) && (pix_cnt != 10'd0) && !rx_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 idle_cnt <= IDLE_LOAD;
        else if (!idle_run)         idle_cnt <= IDLE_LOAD;
        else if (idle_cnt != 23'd0) idle_cnt <= idle_cnt - 23'd1;
    end

    assign idle_expired = idle_run && (idle_cnt == 23'd0);
`else
    assign idle_expired = 1'b0;
`endif

endmodule
